pwm_symbol_framer: RTL and testbench
====================================

Name: pwm_symbol_framer

Overview:
- Sits directly downstream of the PWM symbol decoder and consumes its per-symbol decoded values.
- Hunts for a sync preamble, then parses a length header, the payload and a checksum.
- Payload symbols are buffered in an internal FIFO. A frame becomes visible on the output only after its checksum passes; failed frames are discarded without reaching the output.
- Feeds the host/packet stage over a valid/ready stream.

Parameters:
- SYNC_SYMBOL, 0: preamble symbol value.
- SYNC_LEN, 3: consecutive SYNC_SYMBOLs required for lock.
- MAX_LEN, 16: maximum payload length in symbols.
- FIFO_DEPTH, 32: payload buffer entries; must be a power of 2 and >= MAX_LEN.
- TIMEOUT, 4096: idle cycles allowed between symbols inside a frame.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- symbol_in  in  8  signed decoded symbol from the decoder
- symbol_valid  in  1  one-cycle strobe; symbol_in is valid this cycle
- out_symbol  out  8  payload symbol at the FIFO head
- out_valid  out  1  out_symbol is valid
- out_ready  in  1  consumer accepts the head symbol
- out_last  out  1  head symbol is the last symbol of its frame
- frame_ok  out  1  one-cycle pulse: frame committed
- frame_err  out  1  one-cycle pulse: frame discarded
- err_code  out  2  cause code, valid while frame_err is high
- sync_locked  out  1  high whenever state is not HUNT

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: all outputs 0; state = HUNT; FIFO empty; all counters 0.
- Reset mid-frame: the partial frame is dropped and already-committed data is flushed. No frame_err is raised.
- Symbols are accepted only on cycles where symbol_valid = 1.
- HUNT state:
  - A symbol equal to SYNC_SYMBOL increments the match count; any other symbol clears it to 0.
  - When the count reaches SYNC_LEN, go to LEN.
- LEN state:
  - Further SYNC_SYMBOL values are ignored (the preamble may be longer than SYNC_LEN).
  - A length L outside 1..MAX_LEN, including any negative value: err_code 0, return to HUNT.
  - L greater than free FIFO space: err_code 1, return to HUNT.
  - Otherwise latch L, clear the checksum, go to PAYLOAD.
- PAYLOAD state:
  - Each symbol is written to the FIFO at the speculative write pointer and added to the 8-bit mod-256 checksum.
  - The entry holding the L-th symbol gets last = 1.
  - After L symbols, go to CHK.
- CHK state:
  - If the received symbol equals the checksum: the committed write pointer takes the speculative value and frame_ok pulses.
  - Otherwise: the speculative pointer rolls back to the committed pointer, frame_err pulses with err_code 2.
  - In both cases return to HUNT.
- Abort (err_code 3), applied in LEN, PAYLOAD and CHK:
  - Triggered by a negative symbol (decoder erasure) in PAYLOAD or CHK, or by a TIMEOUT-cycle gap with no symbol_valid in LEN, PAYLOAD or CHK.
  - Action: roll back the speculative pointer, return to HUNT.
- Timeout boundary: the idle counter resets on every symbol_valid. If symbol_valid arrives on the cycle the counter expires, the symbol wins and no abort occurs.
- Pulse timing: frame_ok and frame_err are asserted on the cycle after the deciding symbol is accepted (registered).
- FIFO read side:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - out_valid = (rd_ptr != committed_wr_ptr).
  - out_symbol and out_last reflect mem[rd_ptr] (first-word fall-through).
  - A transfer occurs when out_valid and out_ready are both high; rd_ptr advances.
- FIFO space and concurrency:
  - Free space = FIFO_DEPTH − (spec_wr_ptr − rd_ptr), evaluated in the cycle the header is accepted. A read in that same cycle is not credited.
  - Reads and writes in the same cycle are legal.
  - out_valid first rises in the same cycle frame_ok pulses.
  - Uncommitted data is never visible on the output.

Test Plan:
- Clean frame: symbols 0,0,0,3,5,7,9,21 with out_ready=1 → frame_ok one cycle after 21. Outputs 5, 7, 9 in order; out_last=1 only on 9.
- Bad checksum: 0,0,0,3,5,7,9,22 → frame_err with err_code=2. out_valid stays 0 throughout; a following clean frame then outputs correctly.
- Bad length: 0,0,0,17 → err_code=0, sync_locked falls. A second length test, 0,0,0,0,0,2,4,4,8, locks despite the extra zeros, frame_ok pulses, output is 4,4.
- Backpressure/overflow: out_ready=0; two valid frames with L=16 → 32 entries committed. A third header with L=1 → err_code=1. Then raise out_ready → 32 symbols drain, with out_last on entries 16 and 32.
- Abort: a gap of TIMEOUT cycles after the second payload symbol → err_code=3. Separately, symbol -1 mid-payload → err_code=3. FIFO contents are unchanged in both cases.
- Reset mid-PAYLOAD with a committed frame pending: all outputs go to 0, out_valid=0 the next cycle, state is HUNT.

Source files
------------

// File: rtl/pwm_symbol_framer.sv
// pwm_symbol_framer
// -----------------
// Frames the decoded symbol stream coming out of the PWM symbol decoder.
// It hunts for a run of SYNC_SYMBOL values, reads a signed length header,
// buffers the payload in a FIFO and compares a mod-256 checksum. Payload is
// written at a speculative write pointer. It only becomes visible to the
// reader once the checksum matches and the committed pointer catches up.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   symbol_in    signed decoded symbol (negative values are decoder erasures)
//   symbol_valid one-cycle strobe qualifying symbol_in
//   out_symbol   payload symbol at the FIFO head (0 while out_valid is low)
//   out_valid    a committed symbol is available at the head
//   out_ready    consumer accepts the head symbol this cycle
//   out_last     head symbol is the final symbol of its frame
//   frame_ok     one-cycle pulse, frame committed
//   frame_err    one-cycle pulse, frame discarded
//   err_code     0 bad length, 1 no room, 2 bad checksum, 3 abort
//   sync_locked  high whenever the framer is not hunting for the preamble
module pwm_symbol_framer #(
    parameter logic signed [7:0] SYNC_SYMBOL = 8'sd0,
    parameter int                SYNC_LEN    = 3,
    parameter int                MAX_LEN     = 16,
    parameter int                FIFO_DEPTH  = 32,
    parameter int                TIMEOUT     = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic signed [7:0] symbol_in,
    input  logic              symbol_valid,
    output logic        [7:0] out_symbol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_ok,
    output logic              frame_err,
    output logic        [1:0] err_code,
    output logic              sync_locked
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(SYNC_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [7:0] MAX_LEN_S = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sync_cnt_q, sync_cnt_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic [PW-1:0]   spec_wr_q, spec_wr_d;
    logic [PW-1:0]   commit_wr_q, commit_wr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [7:0]      mem_sym_q  [FIFO_DEPTH];
    logic            mem_last_q [FIFO_DEPTH];

    logic            wr_en;
    logic            wr_last;
    logic [PW-1:0]   free_space;
    logic            timeout_hit;
    logic            is_sync;
    logic            pay_last;

    // Reader side: the head is only exposed once committed. Data and last
    // are forced to 0 when empty so the outputs stay quiet after reset.
    assign out_valid   = (rd_ptr_q != commit_wr_q);
    assign out_symbol  = out_valid ? mem_sym_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign out_last    = out_valid ? mem_last_q[rd_ptr_q[AW-1:0]] : 1'b0;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign sync_locked = (state_q != HUNT);

    // A read in the header cycle is deliberately not credited: rd_ptr_q is
    // the pre-edge value.
    assign free_space  = PW'(FIFO_DEPTH) - (spec_wr_q - rd_ptr_q);
    assign is_sync     = (symbol_in == SYNC_SYMBOL);
    assign pay_last    = ((cnt_q + 8'd1) == len_q);

    // The abort fires on the TIMEOUT-th consecutive idle cycle. A symbol
    // arriving in that same cycle is accepted instead.
    assign timeout_hit = (state_q != HUNT) && !symbol_valid &&
                         (idle_q == TW'(TIMEOUT - 1));

    // Next-state and datapath decisions for the frame parser.
    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        spec_wr_d   = spec_wr_q;
        commit_wr_d = commit_wr_q;
        rd_ptr_d    = rd_ptr_q + PW'(out_valid && out_ready);
        idle_d      = (state_q == HUNT || symbol_valid) ? '0 : idle_q + TW'(1);
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = 2'd0;
        wr_en       = 1'b0;
        wr_last     = 1'b0;

        if (timeout_hit) begin
            spec_wr_d   = commit_wr_q;
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = HUNT;
        end else if (symbol_valid) begin
            case (state_q)
                HUNT: begin
                    if (!is_sync) begin
                        sync_cnt_d = '0;
                    end else if (sync_cnt_q == SW'(SYNC_LEN - 1)) begin
                        sync_cnt_d = '0;
                        state_d    = LEN;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SW'(1);
                    end
                end
                LEN: begin
                    // Extra preamble symbols are skipped here.
                    if (!is_sync) begin
                        if (symbol_in < 8'sd1 || symbol_in > MAX_LEN_S) begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd0;
                            state_d     = HUNT;
                        end else if (int'(symbol_in) > int'(free_space)) begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd1;
                            state_d     = HUNT;
                        end else begin
                            len_d   = $unsigned(symbol_in);
                            cnt_d   = 8'd0;
                            csum_d  = 8'd0;
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (symbol_in[7]) begin
                        spec_wr_d   = commit_wr_q;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd3;
                        state_d     = HUNT;
                    end else begin
                        wr_en     = 1'b1;
                        wr_last   = pay_last;
                        spec_wr_d = spec_wr_q + PW'(1);
                        csum_d    = csum_q + $unsigned(symbol_in);
                        cnt_d     = cnt_q + 8'd1;
                        if (pay_last) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (symbol_in[7]) begin
                        spec_wr_d   = commit_wr_q;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd3;
                    end else if ($unsigned(symbol_in) == csum_q) begin
                        commit_wr_d = spec_wr_q;
                        frame_ok_d  = 1'b1;
                    end else begin
                        spec_wr_d   = commit_wr_q;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State and pointer registers. Reset flushes committed data too and
    // raises no error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HUNT;
            sync_cnt_q  <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            spec_wr_q   <= '0;
            commit_wr_q <= '0;
            rd_ptr_q    <= '0;
            idle_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            spec_wr_q   <= spec_wr_d;
            commit_wr_q <= commit_wr_d;
            rd_ptr_q    <= rd_ptr_d;
            idle_q      <= idle_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload storage. It is not reset: emptiness is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_sym_q[spec_wr_q[AW-1:0]]  <= $unsigned(symbol_in);
            mem_last_q[spec_wr_q[AW-1:0]] <= wr_last;
        end
    end

endmodule

// File: tb/tb_pwm_symbol_framer.sv
// Testbench for pwm_symbol_framer. Frames are built here, and their outcome is
// predicted from the framing rules: length range, room left in the buffer,
// erasures, the idle gap and the checksum sum. Committed payload is queued and
// compared against every symbol the DUT hands out.
module tb_pwm_symbol_framer;

    localparam int SYNC_LEN   = 3;
    localparam int MAX_LEN    = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int TIMEOUT    = 4096;

    logic              clock = 1'b0;
    logic              reset;
    logic signed [7:0] symbol_in;
    logic              symbol_valid;
    logic        [7:0] out_symbol;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              frame_ok;
    logic              frame_err;
    logic        [1:0] err_code;
    logic              sync_locked;

    int          n_checks = 0;
    int          n_fails  = 0;
    bit          rdy_rand = 1'b0;
    logic [7:0]  pay_q[$];
    logic [8:0]  exp_q[$];

    pwm_symbol_framer #(
        .SYNC_SYMBOL (8'sd0),
        .SYNC_LEN    (SYNC_LEN),
        .MAX_LEN     (MAX_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .symbol_in    (symbol_in),
        .symbol_valid (symbol_valid),
        .out_symbol   (out_symbol),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .sync_locked  (sync_locked)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Output monitor. A transfer happens on the next rising edge when both
    // out_valid and out_ready are high.
    always @(negedge clock) begin
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_valid", 32'(out_valid), 32'(0));
            end else begin
                checkOutput("out_data", 32'({out_last, out_symbol}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic sendSym(input logic [7:0] s);
        symbol_in    = s;
        symbol_valid = 1'b1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        symbol_valid = 1'b0;
        symbol_in    = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
    endtask

    task automatic expectErr(input string tag, input logic [1:0] code);
        checkOutput({tag, "_err"}, 32'(frame_err), 32'(1));
        checkOutput({tag, "_code"}, 32'(err_code), 32'(code));
        checkOutput({tag, "_ok"}, 32'(frame_ok), 32'(0));
        checkOutput({tag, "_unlock"}, 32'(sync_locked), 32'(0));
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    endtask

    // Sends one frame: npre sync symbols, the header, pay_q and chk. The
    // outcome is predicted from the framing rules. gap idle cycles are
    // inserted after the second payload symbol.
    task automatic applyStimulus(input int npre, input logic [7:0] len,
                                 input logic [7:0] chk, input int gap,
                                 input string tag);
        int         occ;
        int         l;
        logic [7:0] sum;
        for (int i = 0; i < npre; i++) sendSym(8'h00);
        checkOutput({tag, "_lock"}, 32'(sync_locked), 32'(1));
        occ = exp_q.size();
        l   = int'($signed(len));
        sendSym(len);
        if (l < 1 || l > MAX_LEN) begin
            expectErr(tag, 2'd0);
            return;
        end
        if (l > FIFO_DEPTH - occ) begin
            expectErr(tag, 2'd1);
            return;
        end
        sum = 8'd0;
        for (int i = 0; i < l; i++) begin
            sendSym(pay_q[i]);
            if (pay_q[i][7]) begin
                expectErr(tag, 2'd3);
                return;
            end
            sum = sum + pay_q[i];
            if (i == 1) begin
                if (gap >= TIMEOUT) begin
                    idleCycles(TIMEOUT - 1);
                    checkOutput({tag, "_noabort_yet"}, 32'(frame_err), 32'(0));
                    checkOutput({tag, "_still_locked"}, 32'(sync_locked), 32'(1));
                    idleCycles(1);
                    expectErr(tag, 2'd3);
                    return;
                end
                idleCycles(gap);
            end
        end
        sendSym(chk);
        if (chk[7]) begin
            expectErr(tag, 2'd3);
        end else if (chk == sum) begin
            for (int i = 0; i < l; i++) exp_q.push_back({1'(i == l - 1), pay_q[i]});
            checkOutput({tag, "_ok"}, 32'(frame_ok), 32'(1));
            checkOutput({tag, "_err"}, 32'(frame_err), 32'(0));
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'(1));
        end else begin
            expectErr(tag, 2'd2);
        end
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
        checkOutput({tag, "_empty"}, 32'(out_valid), 32'(0));
    endtask

    function automatic logic [7:0] sumPay();
        logic [7:0] s = 8'd0;
        foreach (pay_q[i]) s = s + pay_q[i];
        return s;
    endfunction

    initial begin
        int         l;
        logic [7:0] len;
        logic [7:0] v;
        logic [7:0] chk;

        reset        = 1'b1;
        symbol_in    = 8'h00;
        symbol_valid = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rst_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_symbol", 32'(out_symbol), 32'(0));
        checkOutput("rst_last", 32'(out_last), 32'(0));
        checkOutput("rst_ok", 32'(frame_ok), 32'(0));
        checkOutput("rst_err", 32'(frame_err), 32'(0));
        checkOutput("rst_code", 32'(err_code), 32'(0));
        checkOutput("rst_lock", 32'(sync_locked), 32'(0));
        reset = 1'b0;

        // Clean frame, then a bad checksum, then a clean frame again
        out_ready = 1'b1;
        pay_q = '{8'd5, 8'd7, 8'd9};
        applyStimulus(3, 8'd3, 8'd21, 0, "clean");
        waitDrain("clean");
        applyStimulus(3, 8'd3, 8'd22, 0, "badchk");
        checkOutput("badchk_novalid", 32'(out_valid), 32'(0));
        applyStimulus(3, 8'd3, 8'd21, 0, "clean2");
        waitDrain("clean2");

        // Bad lengths and a long preamble
        pay_q.delete();
        applyStimulus(3, 8'd17, 8'd0, 0, "len17");
        applyStimulus(3, 8'hFB, 8'd0, 0, "lenneg");
        pay_q = '{8'd4, 8'd4};
        applyStimulus(5, 8'd2, 8'd8, 0, "longpre");
        waitDrain("longpre");

        // Fill the buffer completely, then ask for one more symbol
        out_ready = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 16; i++) pay_q.push_back(8'(i % 8));
        applyStimulus(3, 8'd16, sumPay(), 0, "ovf1");
        pay_q.delete();
        for (int i = 0; i < 16; i++) pay_q.push_back(8'(i % 5 + 1));
        applyStimulus(3, 8'd16, sumPay(), 0, "ovf2");
        pay_q = '{8'd1};
        applyStimulus(3, 8'd1, 8'd1, 0, "ovf3");
        checkOutput("ovf_count", 32'(exp_q.size()), 32'(32));
        out_ready = 1'b1;
        waitDrain("ovf");

        // Aborts with a committed frame waiting
        out_ready = 1'b0;
        pay_q = '{8'd11, 8'd12};
        applyStimulus(3, 8'd2, 8'd23, 0, "pend");
        pay_q = '{8'd1, 8'd2, 8'd3};
        applyStimulus(3, 8'd3, 8'd6, TIMEOUT, "timeout");
        pay_q = '{8'd10, 8'hFF, 8'd3, 8'd4};
        applyStimulus(3, 8'd4, 8'd17, 0, "erasure");
        pay_q = '{8'd1, 8'd2};
        applyStimulus(3, 8'd2, 8'd3, TIMEOUT - 1, "gapedge");
        out_ready = 1'b1;
        waitDrain("abort");

        // Reset in the middle of a payload with a committed frame waiting
        out_ready = 1'b0;
        pay_q = '{8'd6};
        applyStimulus(3, 8'd1, 8'd6, 0, "prerst");
        for (int i = 0; i < 3; i++) sendSym(8'h00);
        sendSym(8'd4);
        sendSym(8'd1);
        sendSym(8'd2);
        reset = 1'b1;
        @(negedge clock);
        exp_q.delete();
        checkOutput("midrst_valid", 32'(out_valid), 32'(0));
        checkOutput("midrst_symbol", 32'(out_symbol), 32'(0));
        checkOutput("midrst_last", 32'(out_last), 32'(0));
        checkOutput("midrst_ok", 32'(frame_ok), 32'(0));
        checkOutput("midrst_err", 32'(frame_err), 32'(0));
        checkOutput("midrst_lock", 32'(sync_locked), 32'(0));
        reset = 1'b0;
        out_ready = 1'b1;
        pay_q = '{8'd5, 8'd7, 8'd9};
        applyStimulus(3, 8'd3, 8'd21, 0, "postrst");
        waitDrain("postrst");

        // Randomized frames with random consumer backpressure
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) sendSym(8'($urandom_range(1, 255)));
            pay_q.delete();
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       len = 8'd17;
                    1:       len = 8'd20;
                    2:       len = 8'hFD;
                    default: len = 8'h80;
                endcase
            end else begin
                len = 8'($urandom_range(1, MAX_LEN));
                l   = int'(len);
                for (int i = 0; i < l; i++) begin
                    v = ($urandom_range(0, 39) == 0) ? 8'hF0 : 8'($urandom_range(0, 20));
                    pay_q.push_back(v);
                end
            end
            chk = sumPay();
            if ($urandom_range(0, 4) == 0) chk = chk + 8'd1;
            applyStimulus(SYNC_LEN + int'($urandom_range(0, 2)), len, chk, 0, "rand");
            idleCycles(int'($urandom_range(0, 2)));
        end
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        waitDrain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
